// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_slave shared definitions: command-byte layout,
// module select codes, FSM states and frame bit counts.
package spi_ctrl_pkg;

    localparam int CMD_RNW_BIT = 7;
    localparam int CMD_SEL_HI  = 6;
    localparam int CMD_SEL_LO  = 5;
    localparam int CMD_IOC_HI  = 4;

    localparam logic [7:0] RSVD_READ_VAL = 8'hFF;

    localparam logic [4:0] BITS_CMD       = 5'd8;
    localparam logic [4:0] BITS_FRAME     = 5'd16;
    localparam logic [4:0] BITS_SAT       = 5'd17;
    localparam logic [4:0] TX_SHIFT_FIRST = 5'd9;
    localparam logic [4:0] TX_SHIFT_LAST  = 5'd15;

    typedef enum logic [1:0] {
        SEL_SYS  = 2'd0,
        SEL_IO   = 2'd1,
        SEL_SMI  = 2'd2,
        SEL_RSVD = 2'd3
    } sel_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_FETCH,
        ST_WAIT,
        ST_LOADTX,
        ST_DATA,
        ST_STROBE,
        ST_DONE
    } state_e;

    function automatic sel_e cmd_sel(input logic [7:0] cmd);
        return sel_e'(cmd[CMD_SEL_HI:CMD_SEL_LO]);
    endfunction

endpackage

// File: rtl/spi_ctrl_if.sv
// Register-access bus between the SPI front-end (master)
// and the control modules (slave).
interface spi_ctrl_if;

    logic [4:0] o_ioc;
    logic [7:0] o_data_out;
    logic       o_cs_sys;
    logic       o_cs_io;
    logic       o_cs_smi;
    logic       o_fetch_cmd;
    logic       o_load_cmd;
    logic [7:0] i_data_sys;
    logic [7:0] i_data_io;
    logic [7:0] i_data_smi;

    modport master (
        output o_ioc, o_data_out,
        output o_cs_sys, o_cs_io, o_cs_smi,
        output o_fetch_cmd, o_load_cmd,
        input  i_data_sys, i_data_io, i_data_smi
    );

    modport slave (
        input  o_ioc, o_data_out,
        input  o_cs_sys, o_cs_io, o_cs_smi,
        input  o_fetch_cmd, o_load_cmd,
        output i_data_sys, i_data_io, i_data_smi
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a
// history flop giving single-cycle rise/fall pulses.
module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, hist_q;
    logic s1_d, s2_d, hist_d;

    // Next values of the synchroniser chain
    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        hist_d = s2_q;
    end

    // Synchroniser and history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            hist_q <= hist_d;
        end
    end

    assign q    = s2_q;
    assign rise = s2_q & ~hist_q;
    assign fall = ~s2_q & hist_q;

endmodule

// File: rtl/spi_ctrl_slave.sv
// SPI mode-0 slave: deserialises 16-bit host frames into
// register-bus fetch/load cycles and returns read data on MISO.
module spi_ctrl_slave
    import spi_ctrl_pkg::*;
#(
    parameter int SCK_RATIO_MIN = 12
) (
    input  logic       i_sys_clk,
    input  logic       i_reset_n,
    input  logic       i_spi_sck,
    input  logic       i_spi_mosi,
    input  logic       i_spi_cs_n,
    output logic       o_spi_miso,
    output logic       o_spi_miso_en,
    output logic       o_frame_err,
    spi_ctrl_if.master bus
);

    // Detected SCK edges must be at least this many cycles apart
    localparam int GAP_MIN = SCK_RATIO_MIN / 2 - 3;

    logic sck_s, sck_rise, sck_fall;
    logic mosi_s, unused_mosi_rise, unused_mosi_fall;
    logic cs_s, cs_rise, cs_fall;

    spi_sync_edge u_sync_sck (
        .clk(i_sys_clk), .rst_n(i_reset_n), .d(i_spi_sck),
        .q(sck_s), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge u_sync_mosi (
        .clk(i_sys_clk), .rst_n(i_reset_n), .d(i_spi_mosi),
        .q(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    spi_sync_edge u_sync_cs (
        .clk(i_sys_clk), .rst_n(i_reset_n), .d(i_spi_cs_n),
        .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d, bits_eff;
    logic [6:0] rx_sr_q, rx_sr_d;
    logic [7:0] cmd_q, cmd_d, rx_byte;
    logic [7:0] tx_sr_q, tx_sr_d, tx_load;
    logic [4:0] ioc_q, ioc_d;
    logic [7:0] dout_q, dout_d;
    logic       cs_sys_q, cs_sys_d, cs_io_q, cs_io_d;
    logic       cs_smi_q, cs_smi_d;
    logic       fetch_q, fetch_d, load_q, load_d;
    logic       err_q, err_d, miso_en_q, miso_en_d;
    logic [3:0] gap_q, gap_d;
    logic       rise_ok, rise8, rise16, tx_shift;
    logic       fetching, strobing, act, sel_ok;
    sel_e       sel_nx;

    // Frame sequencing, shift registers and registered bus outputs
    always_comb begin
        rx_byte  = {rx_sr_q, mosi_s};
        rise_ok  = sck_rise && (state_q != ST_IDLE) && (cnt_q < BITS_SAT);
        bits_eff = cnt_q + {4'd0, rise_ok};
        rise8    = rise_ok && (cnt_q == BITS_CMD - 5'd1);
        rise16   = rise_ok && (cnt_q == BITS_FRAME - 5'd1);
        cnt_d    = cs_s ? 5'd0 : bits_eff;
        rx_sr_d  = rise_ok ? rx_byte[6:0] : rx_sr_q;
        state_d  = state_q;
        cmd_d    = cmd_q;
        if (cs_s && (state_q != ST_IDLE)) begin
            // A 16th rise landing with CS_n rise still completes a write
            state_d = ST_IDLE;
            if ((state_q == ST_DATA) && rise16 && !cmd_q[CMD_RNW_BIT])
                state_d = ST_STROBE;
        end else begin
            unique case (state_q)
                ST_IDLE:   if (cs_fall) state_d = ST_CMD;
                ST_CMD: begin
                    if (rise8) begin
                        cmd_d   = rx_byte;
                        state_d = rx_byte[CMD_RNW_BIT] ? ST_FETCH : ST_DATA;
                    end
                end
                ST_FETCH:  state_d = ST_WAIT;
                ST_WAIT:   state_d = ST_LOADTX;
                ST_LOADTX: state_d = ST_DATA;
                ST_DATA: begin
                    if (rise16)
                        state_d = cmd_q[CMD_RNW_BIT] ? ST_DONE : ST_STROBE;
                end
                ST_STROBE: state_d = ST_DONE;
                ST_DONE:   state_d = ST_DONE;
                default:   state_d = ST_IDLE;
            endcase
        end

        unique case (cmd_sel(cmd_q))
            SEL_SYS: tx_load = bus.i_data_sys;
            SEL_IO:  tx_load = bus.i_data_io;
            SEL_SMI: tx_load = bus.i_data_smi;
            default: tx_load = RSVD_READ_VAL;
        endcase
        tx_shift = sck_fall && (state_q == ST_DATA) &&
                   (cnt_q >= TX_SHIFT_FIRST) && (cnt_q <= TX_SHIFT_LAST);
        tx_sr_d = tx_sr_q;
        if (state_q == ST_IDLE)
            tx_sr_d = 8'h00;
        else if (state_q == ST_LOADTX)
            tx_sr_d = tx_load;
        else if (tx_shift)
            tx_sr_d = {tx_sr_q[6:0], 1'b0};

        fetching  = (state_d == ST_FETCH);
        strobing  = (state_d == ST_STROBE);
        act       = fetching || strobing;
        sel_nx    = cmd_sel(cmd_d);
        sel_ok    = (sel_nx != SEL_RSVD);
        fetch_d   = fetching && sel_ok;
        load_d    = strobing && sel_ok;
        ioc_d     = (act && sel_ok) ? cmd_d[CMD_IOC_HI:0] : 5'd0;
        dout_d    = load_d ? rx_byte : 8'h00;
        cs_sys_d  = act && (sel_nx == SEL_SYS);
        cs_io_d   = act && (sel_nx == SEL_IO);
        cs_smi_d  = act && (sel_nx == SEL_SMI);
        err_d     = cs_rise && (state_q != ST_IDLE) && (bits_eff != BITS_FRAME);
        miso_en_d = !cs_s && (state_d != ST_IDLE);
        gap_d     = (sck_rise || sck_fall) ? 4'd0 :
                    ((gap_q == 4'hF) ? gap_q : gap_q + 4'd1);
    end

    // Single state/output register bank
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            rx_sr_q   <= 7'd0;
            cmd_q     <= 8'd0;
            tx_sr_q   <= 8'd0;
            ioc_q     <= 5'd0;
            dout_q    <= 8'd0;
            cs_sys_q  <= 1'b0;
            cs_io_q   <= 1'b0;
            cs_smi_q  <= 1'b0;
            fetch_q   <= 1'b0;
            load_q    <= 1'b0;
            err_q     <= 1'b0;
            miso_en_q <= 1'b0;
            gap_q     <= 4'hF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_sr_q   <= rx_sr_d;
            cmd_q     <= cmd_d;
            tx_sr_q   <= tx_sr_d;
            ioc_q     <= ioc_d;
            dout_q    <= dout_d;
            cs_sys_q  <= cs_sys_d;
            cs_io_q   <= cs_io_d;
            cs_smi_q  <= cs_smi_d;
            fetch_q   <= fetch_d;
            load_q    <= load_d;
            err_q     <= err_d;
            miso_en_q <= miso_en_d;
            gap_q     <= gap_d;
        end
    end

    assert property (@(posedge i_sys_clk) disable iff (!i_reset_n)
        (sck_rise || sck_fall) |-> (int'(gap_q) >= GAP_MIN));

    assign o_spi_miso      = tx_sr_q[7];
    assign o_spi_miso_en   = miso_en_q;
    assign o_frame_err     = err_q;
    assign bus.o_ioc       = ioc_q;
    assign bus.o_data_out  = dout_q;
    assign bus.o_cs_sys    = cs_sys_q;
    assign bus.o_cs_io     = cs_io_q;
    assign bus.o_cs_smi    = cs_smi_q;
    assign bus.o_fetch_cmd = fetch_q;
    assign bus.o_load_cmd  = load_q;

endmodule

// File: tb/tb_spi_ctrl_slave.sv
// Directed-vector bench for spi_ctrl_slave: writes, reads,
// reserved select, aborted frames, reset and back-to-back.
module tb_spi_ctrl_slave;

    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0;
    logic mosi = 1'b0;
    logic cs_n = 1'b1;
    logic miso, miso_en, frame_err;

    spi_ctrl_if bus ();

    spi_ctrl_slave #(.SCK_RATIO_MIN(12)) dut (
        .i_sys_clk(clk), .i_reset_n(rst_n),
        .i_spi_sck(sck), .i_spi_mosi(mosi), .i_spi_cs_n(cs_n),
        .o_spi_miso(miso), .o_spi_miso_en(miso_en),
        .o_frame_err(frame_err), .bus(bus)
    );

    always #5 clk = ~clk;

    // Module register model: data appears one cycle after fetch
    logic [7:0] mdl_sys = 8'h00, mdl_io = 8'h00, mdl_smi = 8'h00;
    logic [7:0] dsys_q = 8'h00, dio_q = 8'h00, dsmi_q = 8'h00;
    always @(posedge clk) begin
        if (bus.o_fetch_cmd && bus.o_cs_sys) dsys_q <= mdl_sys;
        if (bus.o_fetch_cmd && bus.o_cs_io)  dio_q  <= mdl_io;
        if (bus.o_fetch_cmd && bus.o_cs_smi) dsmi_q <= mdl_smi;
    end
    assign bus.i_data_sys = dsys_q;
    assign bus.i_data_io  = dio_q;
    assign bus.i_data_smi = dsmi_q;

    // Bus monitor
    int n_load = 0, n_fetch = 0, n_err = 0, n_bad = 0, n_cs = 0;
    logic [15:0] ld_log[$];
    logic [7:0]  fe_log[$];
    logic [2:0]  csv;
    always @(negedge clk) begin
        if (rst_n) begin
            csv = {bus.o_cs_sys, bus.o_cs_io, bus.o_cs_smi};
            if (csv != 3'b000) n_cs++;
            if ($countones(csv) > 1 ||
                (bus.o_fetch_cmd && bus.o_load_cmd) ||
                ((csv != 3'b000) && !(bus.o_fetch_cmd || bus.o_load_cmd)) ||
                ((bus.o_fetch_cmd || bus.o_load_cmd) && (csv == 3'b000)))
                n_bad++;
            if (bus.o_load_cmd) begin
                n_load++;
                ld_log.push_back({csv, bus.o_ioc, bus.o_data_out});
            end
            if (bus.o_fetch_cmd) begin
                n_fetch++;
                fe_log.push_back({csv, bus.o_ioc});
            end
            if (frame_err) n_err++;
        end
    end

    int n_cmp = 0, n_fail = 0;
    logic [15:0] rx_cap;
    logic        en_seen;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [15:0] tx, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            mosi = tx[15 - i];
            wait_cyc(HALF);
            rx_cap[15 - i] = miso;
            if (i == 8) en_seen = miso_en;
            sck = 1'b1;
            wait_cyc(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic spi_xfer(input logic [15:0] tx, input int nbits);
        rx_cap = 16'h0000;
        en_seen = 1'b0;
        cs_n = 1'b0;
        wait_cyc(HALF);
        spi_bits(tx, 0, nbits - 1);
        wait_cyc(HALF);
        cs_n = 1'b1;
        wait_cyc(4);
    endtask

    task automatic test_reset();
        wait_cyc(3);
        n_cmp++;
        if ({miso, miso_en, frame_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pins: got %b want 000", {miso, miso_en, frame_err});
        end
        n_cmp++;
        if ({bus.o_ioc, bus.o_data_out} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_bus_data: got %h want 0", {bus.o_ioc, bus.o_data_out});
        end
        n_cmp++;
        if ({bus.o_cs_sys, bus.o_cs_io, bus.o_cs_smi, bus.o_fetch_cmd, bus.o_load_cmd} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_bus_strobes: got %b want 00000",
                     {bus.o_cs_sys, bus.o_cs_io, bus.o_cs_smi, bus.o_fetch_cmd, bus.o_load_cmd});
        end
        rst_n = 1'b1;
        wait_cyc(6);
        n_cmp++;
        if ({miso_en, frame_err, bus.o_load_cmd} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b want 000", {miso_en, frame_err, bus.o_load_cmd});
        end
    endtask

    task automatic test_write();
        int l0, f0, e0;
        l0 = n_load; f0 = n_fetch; e0 = n_err;
        spi_xfer(16'h04A5, 16);
        wait_cyc(4);
        n_cmp++;
        if (n_load - l0 !== 1) begin
            n_fail++;
            $display("FAIL write_load_count: got %0d want 1", n_load - l0);
        end
        n_cmp++;
        if (ld_log[$] !== {3'b100, 5'd4, 8'hA5}) begin
            n_fail++;
            $display("FAIL write_strobe: got %h want %h", ld_log[$], {3'b100, 5'd4, 8'hA5});
        end
        n_cmp++;
        if (n_fetch - f0 !== 0) begin
            n_fail++;
            $display("FAIL write_no_fetch: got %0d want 0", n_fetch - f0);
        end
        n_cmp++;
        if (n_err - e0 !== 0) begin
            n_fail++;
            $display("FAIL write_no_err: got %0d want 0", n_err - e0);
        end
    endtask

    task automatic test_read();
        int l0, f0;
        l0 = n_load; f0 = n_fetch;
        mdl_sys = 8'h01;
        spi_xfer(16'h8000, 16);
        wait_cyc(4);
        n_cmp++;
        if (n_fetch - f0 !== 1) begin
            n_fail++;
            $display("FAIL read_fetch_count: got %0d want 1", n_fetch - f0);
        end
        n_cmp++;
        if (fe_log[$] !== {3'b100, 5'd0}) begin
            n_fail++;
            $display("FAIL read_fetch_sel: got %h want %h", fe_log[$], {3'b100, 5'd0});
        end
        n_cmp++;
        if (rx_cap !== 16'h0001) begin
            n_fail++;
            $display("FAIL read_miso: got %h want 0001", rx_cap);
        end
        n_cmp++;
        if (en_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL read_miso_en: got %b want 1", en_seen);
        end
        n_cmp++;
        if (n_load - l0 !== 0) begin
            n_fail++;
            $display("FAIL read_no_load: got %0d want 0", n_load - l0);
        end
        mdl_io = 8'hC6;
        spi_xfer(16'hA900, 16);
        n_cmp++;
        if (rx_cap !== 16'h00C6) begin
            n_fail++;
            $display("FAIL read_io_miso: got %h want 00c6", rx_cap);
        end
    endtask

    task automatic test_reserved_read();
        int c0;
        c0 = n_cs;
        spi_xfer(16'hE300, 16);
        wait_cyc(4);
        n_cmp++;
        if (n_cs - c0 !== 0) begin
            n_fail++;
            $display("FAIL rsvd_no_cs: got %0d want 0", n_cs - c0);
        end
        n_cmp++;
        if (rx_cap !== 16'h00FF) begin
            n_fail++;
            $display("FAIL rsvd_miso: got %h want 00ff", rx_cap);
        end
    endtask

    task automatic test_short_write();
        int l0, e0;
        l0 = n_load; e0 = n_err;
        spi_xfer(16'h04A5, 10);
        wait_cyc(4);
        n_cmp++;
        if (n_load - l0 !== 0) begin
            n_fail++;
            $display("FAIL short_no_load: got %0d want 0", n_load - l0);
        end
        n_cmp++;
        if (n_err - e0 !== 1) begin
            n_fail++;
            $display("FAIL short_err_pulse: got %0d want 1", n_err - e0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int l0, e0;
        l0 = n_load; e0 = n_err;
        cs_n = 1'b0;
        wait_cyc(HALF);
        spi_bits(16'h04A5, 0, 11);
        rst_n = 1'b0;
        wait_cyc(2);
        n_cmp++;
        if ({miso, miso_en, frame_err, bus.o_load_cmd, bus.o_cs_sys, bus.o_ioc, bus.o_data_out} !== 18'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h want 0",
                     {miso, miso_en, frame_err, bus.o_load_cmd, bus.o_cs_sys, bus.o_ioc, bus.o_data_out});
        end
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(HALF);
        spi_bits(16'h04A5, 12, 15);
        wait_cyc(HALF);
        cs_n = 1'b1;
        wait_cyc(8);
        n_cmp++;
        if (n_load - l0 !== 0) begin
            n_fail++;
            $display("FAIL midrst_no_load: got %0d want 0", n_load - l0);
        end
        n_cmp++;
        if (n_err - e0 !== 0) begin
            n_fail++;
            $display("FAIL midrst_no_err: got %0d want 0", n_err - e0);
        end
        spi_xfer(16'h243C, 16);
        wait_cyc(4);
        n_cmp++;
        if (n_load - l0 !== 1) begin
            n_fail++;
            $display("FAIL midrst_next_count: got %0d want 1", n_load - l0);
        end
        n_cmp++;
        if (ld_log[$] !== {3'b010, 5'd4, 8'h3C}) begin
            n_fail++;
            $display("FAIL midrst_next_strobe: got %h want %h", ld_log[$], {3'b010, 5'd4, 8'h3C});
        end
    endtask

    task automatic test_cs_coincident();
        int l0, e0;
        l0 = n_load; e0 = n_err;
        cs_n = 1'b0;
        wait_cyc(HALF);
        spi_bits(16'h2B96, 0, 14);
        mosi = 1'b0;
        wait_cyc(HALF);
        sck = 1'b1;
        cs_n = 1'b1;
        wait_cyc(HALF);
        sck = 1'b0;
        wait_cyc(8);
        n_cmp++;
        if (n_load - l0 !== 1) begin
            n_fail++;
            $display("FAIL coinc_load_count: got %0d want 1", n_load - l0);
        end
        n_cmp++;
        if (ld_log[$] !== {3'b010, 5'h0B, 8'h96}) begin
            n_fail++;
            $display("FAIL coinc_strobe: got %h want %h", ld_log[$], {3'b010, 5'h0B, 8'h96});
        end
        n_cmp++;
        if (n_err - e0 !== 0) begin
            n_fail++;
            $display("FAIL coinc_no_err: got %0d want 0", n_err - e0);
        end
    endtask

    task automatic test_back_to_back();
        int l0, e0;
        l0 = n_load; e0 = n_err;
        spi_xfer(16'h415A, 16);
        spi_xfer(16'h27C3, 16);
        wait_cyc(4);
        n_cmp++;
        if (n_load - l0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_load_count: got %0d want 2", n_load - l0);
        end
        n_cmp++;
        if (ld_log[ld_log.size() - 2] !== {3'b001, 5'd1, 8'h5A}) begin
            n_fail++;
            $display("FAIL b2b_first: got %h want %h", ld_log[ld_log.size() - 2], {3'b001, 5'd1, 8'h5A});
        end
        n_cmp++;
        if (ld_log[$] !== {3'b010, 5'd7, 8'hC3}) begin
            n_fail++;
            $display("FAIL b2b_second: got %h want %h", ld_log[$], {3'b010, 5'd7, 8'hC3});
        end
        n_cmp++;
        if (n_err - e0 !== 0) begin
            n_fail++;
            $display("FAIL b2b_no_err: got %0d want 0", n_err - e0);
        end
        n_cmp++;
        if (n_bad !== 0) begin
            n_fail++;
            $display("FAIL bus_exclusive: got %0d bad cycles want 0", n_bad);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_reserved_read();
        test_short_write();
        test_reset_mid_frame();
        test_cs_coincident();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
